// File: rtl/usb_packet_reader_pkg.sv
// Shared definitions for the FX2 packet stream: header values, FIFO addresses,
// packet length and the byte-read FSM encoding.
package usb_packet_reader_pkg;

  localparam logic [7:0] PKT_DATA_HDR = 8'hAA;
  // Value of byte-0 bit 7 that marks an address packet
  localparam logic       PKT_ADDR_MSB = 1'b0;
  localparam logic [1:0] FIFOADR_EP2  = 2'b00;
  localparam logic [1:0] FIFOADR_EP6  = 2'b10;
  localparam int         PKT_LEN      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OE,
    ST_SAMPLE,
    ST_STROBE,
    ST_SETTLE
  } rd_state_e;

  typedef struct packed {
    logic        is_data;
    logic [22:0] addr;
    logic [15:0] data;
  } cmd_t;

endpackage

// File: rtl/d_flipflop_pair.sv
// Two-flop synchroniser for a single asynchronous level.
module d_flipflop_pair (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/usb_packet_reader_decoder.sv
// Byte-stream packet decoder: header check, payload assembly, command register
// with valid/ready hold, packet and sync-error counters.
module usb_packet_reader_decoder
  import usb_packet_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  input  logic        cmd_ready_i,
  output cmd_t        cmd_o,
  output logic        cmd_valid_o,
  output logic        sync_err_o,
  output logic [15:0] pkt_count_o,
  output logic [7:0]  err_count_o
);

  logic [1:0]  idx_q, idx_d;
  logic        hdr_q, hdr_d;
  logic [6:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  cmd_t        cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic        serr_q, serr_d;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  err_q, err_d;

  always_comb begin
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    cmd_d   = cmd_q;
    serr_d  = 1'b0;
    pkt_d   = pkt_q;
    err_d   = err_q;
    // A completion in the same cycle as a handshake overrides the clear below
    valid_d = valid_q && !cmd_ready_i;
    if (byte_vld_i) begin
      if (idx_q == 2'd0) begin
        if (byte_i[7] == PKT_ADDR_MSB) begin
          hdr_d = 1'b0;
          b0_d  = byte_i[6:0];
          idx_d = 2'd1;
        end else if (byte_i == PKT_DATA_HDR) begin
          hdr_d = 1'b1;
          idx_d = 2'd1;
        end else begin
          serr_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end else if (idx_q == 2'd1) begin
        b1_d  = byte_i;
        idx_d = 2'(PKT_LEN - 1);
      end else begin
        cmd_d.is_data = hdr_q;
        if (hdr_q) cmd_d.data = {b1_q, byte_i};
        else       cmd_d.addr = {b0_q, b1_q, byte_i};
        valid_d = 1'b1;
        pkt_d   = pkt_q + 16'd1;
        idx_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      hdr_q   <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      serr_q  <= serr_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = valid_q;
  assign sync_err_o  = serr_q;
  assign pkt_count_o = pkt_q;
  assign err_count_o = err_q;

endmodule

// File: rtl/usb_packet_reader.sv
// Drains the FX2 EP2 OUT FIFO with SLOE/SLRD strobes and hands each byte to
// the packet decoder; stalls new reads while a command is held by the consumer.
module usb_packet_reader
  import usb_packet_reader_pkg::*;
#(
  parameter int OE_SETUP    = 2,
  parameter int RD_PULSE    = 2,
  parameter int FLAG_SETTLE = 3
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  usb_d,
  input  logic        usb_flaga,
  output logic [1:0]  usb_fifoadr,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_is_data,
  output logic [22:0] cmd_addr,
  output logic [15:0] cmd_data,
  output logic        sync_err,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam int CW = 4;
  localparam logic [CW-1:0] OE_LAST  = CW'(OE_SETUP - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_PULSE - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(FLAG_SETTLE - 1);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sloe_q, slrd_q;
  logic          flaga_sync, fifo_empty;
  cmd_t          cmd;

  d_flipflop_pair u_flag_sync (
    .clk   (mclk),
    .rst_n (reset),
    .d_i   (usb_flaga),
    .q_o   (flaga_sync)
  );

  assign fifo_empty = !flaga_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !(cmd_valid && !cmd_ready)) begin
          state_d = ST_OE;
          cnt_d   = '0;
        end
      end
      ST_OE: begin
        if (cnt_q == OE_LAST) state_d = ST_SAMPLE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_SAMPLE: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == RD_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they switch glitch-free
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sloe_q  <= 1'b1;
      slrd_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sloe_q  <= !(state_d inside {ST_OE, ST_SAMPLE, ST_STROBE});
      slrd_q  <= (state_d != ST_STROBE);
    end
  end

  usb_packet_reader_decoder u_dec (
    .clk         (mclk),
    .rst_n       (reset),
    .byte_vld_i  (state_q == ST_SAMPLE),
    .byte_i      (usb_d),
    .cmd_ready_i (cmd_ready),
    .cmd_o       (cmd),
    .cmd_valid_o (cmd_valid),
    .sync_err_o  (sync_err),
    .pkt_count_o (pkt_count),
    .err_count_o (err_count)
  );

  assign usb_fifoadr = FIFOADR_EP2;
  assign usb_sloe    = sloe_q;
  assign usb_slrd    = slrd_q;
  assign cmd_is_data = cmd.is_data;
  assign cmd_addr    = cmd.addr;
  assign cmd_data    = cmd.data;

endmodule
